// File: rtl/dot8_pkg.sv
// Shared definitions for the dot8_acc dot-product stage: FSM states, product
// width and the accumulator-width rule used to check parameters.
package dot8_pkg;

  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  function automatic int unsigned acc_w_min(input int unsigned len);
    return PROD_W + $clog2(len);
  endfunction

endpackage

// File: rtl/mul8.sv
// MUL8: combinational 8x8 natural multiplier with a full 16-bit product.
module mul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = 16'(a) * 16'(b);

endmodule

// File: rtl/dot8_acc.sv
// dot8_acc: accumulates LEN MUL8 products behind valid/ready handshakes.
// Define DOT8_ACC_PIPE_EN to register the product ahead of the adder.
module dot8_acc
  import dot8_pkg::*;
#(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 18
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  if (LEN < 1 || ACC_W < acc_w_min(LEN)) begin : g_param_chk
    $error("dot8_acc: need LEN >= 1 and ACC_W >= 16 + clog2(LEN)");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [PROD_W-1:0] p;
  logic              accept;
  logic              last;

  mul8 mul (
    .a (x),
    .b (y),
    .p (p)
  );

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign sum       = sum_q;
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == CNT_LAST);

`ifdef DOT8_ACC_PIPE_EN
  logic [PROD_W-1:0] p_reg_q, p_reg_d;
  logic              p_vld_q, p_vld_d;

  // acc is zero at every group start, so acc + p_reg covers the cnt==0 case.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    p_reg_d = accept ? p : p_reg_q;
    p_vld_d = accept;
    unique case (state_q)
      ST_ACC: begin
        if (p_vld_q) acc_d = acc_q + ACC_W'(p_reg_q);
        if (accept) begin
          if (last) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        sum_d   = acc_q + ACC_W'(p_reg_q);
        acc_d   = '0;
        state_d = ST_OUT;
      end
      ST_OUT: if (out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      p_reg_q <= '0;
      p_vld_q <= 1'b0;
    end else begin
      p_reg_q <= p_reg_d;
      p_vld_q <= p_vld_d;
    end
  end
`else
  // acc is zero at every group start, so acc + p covers the cnt==0 case.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (last) begin
            sum_d   = acc_q + ACC_W'(p);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_OUT;
          end else begin
            acc_d = acc_q + ACC_W'(p);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: if (out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end
`endif

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_dot8_acc.sv
// Randomized and directed checks of dot8_acc (LEN=4 and LEN=1 instances on
// shared stimulus) against a group-sum/timeline reference model.
module tb_dot8_acc;

`ifdef DOT8_ACC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N = 2;

  logic        clock = 1'b0;
  logic        reset_;
  logic [7:0]  x, y;
  logic        in_valid, out_ready;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [17:0] sum0;
  logic [15:0] sum1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dot8_acc #(.LEN(4), .ACC_W(18)) u_dut4 (
    .clock(clock), .reset_(reset_), .x(x), .y(y),
    .in_valid(in_valid), .in_ready(in_ready0),
    .sum(sum0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  dot8_acc #(.LEN(1), .ACC_W(16)) u_dut1 (
    .clock(clock), .reset_(reset_), .x(x), .y(y),
    .in_valid(in_valid), .in_ready(in_ready1),
    .sum(sum1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  // Reference model: running group sum, and a blocked window that opens at the
  // LEN-th accept and closes at the output handshake.
  int    lens     [N] = '{4, 1};
  int    acc_m    [N];
  int    cnt_m    [N];
  bit    blocked  [N];
  int    vis_cyc  [N];
  int    exp_sum  [N];
  int    got_last [N];
  int    last_hs  [N];
  int    prev_hs  [N];
  int    cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      acc_m[i]   = 0;
      cnt_m[i]   = 0;
      blocked[i] = 1'b0;
      vis_cyc[i] = 0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] xv, input logic [7:0] yv,
                      input logic ordy);
    logic [N-1:0] ir, ov;
    logic [31:0]  sm [N];
    bit           e_ir, e_ov;
    @(negedge clock);
    in_valid  = v;
    x         = xv;
    y         = yv;
    out_ready = ordy;
    ir    = {in_ready1, in_ready0};
    ov    = {out_valid1, out_valid0};
    sm[0] = 32'(sum0);
    sm[1] = 32'(sum1);
    for (int i = 0; i < N; i++) begin
      e_ir = !blocked[i];
      e_ov = blocked[i] && (cyc >= vis_cyc[i]);
      chk($sformatf("in_ready[%0d]@%0d", i, cyc), 32'(ir[i]), 32'(e_ir));
      chk($sformatf("out_valid[%0d]@%0d", i, cyc), 32'(ov[i]), 32'(e_ov));
      if (e_ov) chk($sformatf("sum[%0d]@%0d", i, cyc), sm[i], 32'(exp_sum[i]));
      if (e_ov && ordy) begin
        blocked[i]  = 1'b0;
        got_last[i] = int'(sm[i]);
        prev_hs[i]  = last_hs[i];
        last_hs[i]  = cyc;
      end else if (v && e_ir) begin
        acc_m[i] += int'(xv) * int'(yv);
        cnt_m[i]++;
        if (cnt_m[i] == lens[i]) begin
          exp_sum[i] = acc_m[i];
          acc_m[i]   = 0;
          cnt_m[i]   = 0;
          blocked[i] = 1'b1;
          vis_cyc[i] = cyc + LAT;
        end
      end
    end
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (blocked[0] || blocked[1]); k++) step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("drain_timeout", 32'(blocked[0] | blocked[1]), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    chk("rst_out_valid0", 32'(out_valid0), 32'd0);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    chk("rst_in_ready0", 32'(in_ready0), 32'd1);
    chk("rst_sum0", 32'(sum0), 32'd0);
    #1 reset_ = 1'b1;
    model_reset();
    cyc++;
  endtask

  initial begin
    logic [7:0] t2x [4] = '{8'd3, 8'd0, 8'd16, 8'd1};
    logic [7:0] t2y [4] = '{8'd5, 8'd200, 8'd16, 8'd1};
    reset_    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    model_reset();
    #1;
    chk("init_sum0", 32'(sum0), 32'd0);
    chk("init_out_valid0", 32'(out_valid0), 32'd0);
    @(negedge clock);
    #2 reset_ = 1'b1;

    // 1: max operands, in_valid held high
    for (int k = 0; k < 4; k++) step(1'b1, 8'd255, 8'd255, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    drain();
    chk("t1_sum", 32'(got_last[0]), 32'd260100);

    // 2: gaps between pairs
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      step(1'b1, t2x[k], t2y[k], 1'b0);
    end
    drain();
    chk("t2_sum", 32'(got_last[0]), 32'd272);

    // 3: back-pressure with ignored input pairs
    for (int k = 0; k < 4; k++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    repeat (LAT + 5) step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    drain();

    // 4: reset in the middle of a group
    step(1'b1, 8'd10, 8'd10, 1'b0);
    step(1'b1, 8'd10, 8'd10, 1'b0);
    pulse_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 8'd1, 8'd2, 1'b0);
    drain();
    chk("t4_sum", 32'(got_last[0]), 32'd8);

    // 5: LEN=1 instance
    pulse_reset();
    step(1'b1, 8'd200, 8'd100, 1'b0);
    drain();
    chk("t5_sum_a", 32'(got_last[1]), 32'd20000);
    step(1'b1, 8'd7, 8'd9, 1'b0);
    drain();
    chk("t5_sum_b", 32'(got_last[1]), 32'd63);

    // 6: back-to-back groups, out_ready high
    pulse_reset();
    for (int g = 0; g < 3; g++) begin
      for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 8'(k), 1'b1);
      repeat (LAT) step(1'b0, 8'd0, 8'd0, 1'b1);
      chk($sformatf("t6_sum_g%0d", g), 32'(got_last[0]), 32'd30);
      if (g > 0) chk($sformatf("t6_period_g%0d", g), 32'(last_hs[0] - prev_hs[0]), 32'(4 + LAT));
    end

    // 7: random traffic
    pulse_reset();
    for (int k = 0; k < 2000; k++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dot8_acc.md
Name: dot8_acc

Overview:
- Sequential dot-product stage built around the combinational 8x8 natural multiplier (MUL8).
- Accepts a stream of (x, y) operand pairs through a valid/ready handshake, multiplies each pair with an internal MUL8 instance, and accumulates LEN products.
- Presents the accumulated sum through a valid/ready output handshake.
- Sits directly downstream of MUL8: it consumes the 16-bit products MUL8 produces.

Parameters:
- LEN, 4: number of products per result; must be >= 1.
- ACC_W, 18: accumulator and sum width. Must be >= 16 + ceil(log2(LEN)); elaboration fails (`$error` in an initial/generate check) otherwise, so overflow cannot occur.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset_, input, 1: asynchronous, active-low reset.
- x, input, 8: natural operand.
- y, input, 8: natural operand.
- in_valid, input, 1: x/y carry a valid pair.
- in_ready, output, 1: block accepts a pair this cycle. Accept = in_valid & in_ready.
- sum, output, ACC_W: natural sum of LEN products x*y.
- out_valid, output, 1: sum is valid.
- out_ready, input, 1: consumer takes sum. Output handshake = out_valid & out_ready.

Behaviour:
- Reset (async, reset_=0):
  - state=ACC, cnt=0, acc=0.
  - sum=0, out_valid=0.
  - in_ready=1 once reset_ is deasserted.
  - Asserting reset_ mid-operation discards any partial accumulation or pending result, with no output.
- Product p = MUL8(x, y), 16 bits, zero-extended to ACC_W.
- State ACC:
  - in_ready=1, out_valid=0.
  - On accept with cnt < LEN-1: acc <= (cnt==0 ? p : acc + p); cnt <= cnt+1.
  - On accept with cnt == LEN-1: sum <= (cnt==0 ? p : acc + p); cnt <= 0; acc <= 0; state <= OUT.
  - No accept: all registers hold. Gaps in in_valid are allowed anywhere in a group.
- State OUT:
  - out_valid=1, in_ready=0.
  - sum is stable while out_valid=1 and out_ready=0, for unbounded back-pressure.
  - On out_valid & out_ready: out_valid <= 0, state <= ACC. sum keeps its last value but is meaningless while out_valid=0.
- Latency: out_valid rises on the clock edge after the LEN-th accept.
- Throughput: at most one result per LEN+1 cycles. There is one mandatory bubble cycle, because in_ready=0 in OUT.
- LEN=1: every accept goes directly to OUT with sum = p.
- in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready to either output.
- cnt width: max(1, ceil(log2(LEN))).

Optional Feature:
- Macro: DOT8_ACC_PIPE_EN.
- When defined:
  - The MUL8 output is registered (p_reg plus p_vld) before the adder, cutting the multiplier-to-adder path.
  - The accumulate step uses p_reg one cycle after the accept.
  - After the LEN-th accept, the FSM enters state DRAIN for one cycle (in_ready=0, out_valid=0). The final add happens in DRAIN, then the FSM goes to OUT.
  - Latency becomes 2 cycles after the LEN-th accept; minimum period becomes LEN+2 cycles.
  - Back-to-back accepts in ACC still accumulate correctly, because p_reg is added while the next product is being registered.
  - Reset also clears p_reg and p_vld.
- When undefined: no DRAIN state, no p_reg; behaviour is exactly as above.

Decomposition:
- Shared package dot8_pkg:
  - State encoding constants ST_ACC, ST_DRAIN, ST_OUT (2 bits).
  - Product width constant PROD_W=16.
  - Function acc_w_min(len) returning 16 + clog2(len), used by the parameter check.
- One sub-module: the existing MUL8, instantiated once as mul. No new sub-module is needed; the FSM, counter and accumulator live in dot8_acc.

Test Plan:
1. LEN=4, ACC_W=18, pairs (255,255) x4 with in_valid held high → sum=260100 (0x3F804); out_valid 1 cycle after the 4th accept (2 with DOT8_ACC_PIPE_EN); in_ready=0 while out_valid=1.
2. LEN=4, pairs (3,5),(0,200),(16,16),(1,1) with in_valid gaps of 0–3 cycles between pairs → sum=272; registers hold across gaps.
3. Back-pressure: a result is pending and out_ready=0 for 5 cycles → sum and out_valid stable, in_ready=0, in_valid pairs ignored; one cycle after out_ready=1, in_ready=1.
4. Reset mid-group: 2 of 4 pairs (10,10) accepted, then reset_ pulsed low asynchronously (between edges) → out_valid=0, in_ready=1; the next group of four (1,2) gives sum=8, not 208.
5. LEN=1, ACC_W=16, stream (200,100),(7,9) → sums 20000 then 63, each followed by one bubble cycle with in_ready=0.
6. Back-to-back groups, LEN=4, out_ready tied high, operands (1,1),(2,2),(3,3),(4,4) repeated → sum=30 every 5 cycles (6 with DOT8_ACC_PIPE_EN); the accumulator starts clean for each group.
